// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped down-counting timer with a one-shot mode and an auto-reload
// mode. It raises a maskable interrupt when the count expires. The bridge
// decodes the base address and asserts WE only for valid word stores. This
// block decodes only the register offset, Addr[3:2].
//
// Register map (byte offsets):
//   0x0 CTRL   : [0] En, [2:1] Mode, [3] IM; bits [31:4] read as 0
//   0x4 PRESET : read/write reload value
//   0x8 COUNT  : read-only current count
//   0xC        : reads 0, writes ignored
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   Addr   in   30  word address [31:2]; only [3:2] decoded
//   WE     in   1   register write strobe
//   Din    in   32  write data
//   Dout   out  32  combinational read data for the selected register
//   IRQ    out  1   interrupt request (IM & IntF)
// -----------------------------------------------------------------------------
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        int_f;

    logic        ctrl_we;
    logic        preset_we;

    assign ctrl_we   = WE && (Addr[3:2] == OFF_CTRL);
    assign preset_we = WE && (Addr[3:2] == OFF_PRESET);

    // The base address is decoded by the bridge, so the upper address bits
    // are intentionally unused here.
    logic unused_addr;
    assign unused_addr = ^Addr[31:4];

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            preset <= 32'd0;
            count  <= 32'd0;
            int_f  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // A PRESET of 0 also lands here, so COUNT never wraps.
                        count <= 32'd0;
                        int_f <= 1'b1;
                        state <= INT;
                    end
                end
                INT: begin
                    if (mode == MODE_RELOAD) begin
                        int_f <= 1'b0;
                    end else begin
                        en <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // NOTE: these bus writes come after the FSM updates in the same
            // block. The last non-blocking assignment wins, so a CTRL write
            // overrides any FSM change to En or IntF on the same edge. The
            // state transition above still happens on that edge.
            if (ctrl_we) begin
                en    <= Din[0];
                mode  <= Din[2:1];
                im    <= Din[3];
                int_f <= 1'b0;
            end
            if (preset_we) begin
                preset <= Din;
            end
        end
    end

    // NOTE: Dout gets a default before the case statement, so no latch can
    // be inferred even for unlisted offsets.
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            OFF_CTRL:   Dout = {28'd0, im, mode, en};
            OFF_PRESET: Dout = preset;
            OFF_COUNT:  Dout = count;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = im & int_f;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Directed bench for timer_counter. Expected values are pushed to a scoreboard
// queue when a check is set up. Each one is popped and compared against the
// DUT output that is sampled 1 ns or more after the rising edge.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (addr),
        .WE    (we),
        .Din   (din),
        .Dout  (dout),
        .IRQ   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:2] word_addr(input int offset);
        logic [31:0] a;
        a = 32'h0000_7f00 | 32'(offset);
        return a[31:2];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Store data on the next rising edge; returns 1 ns after that edge.
    task automatic wr(input int offset, input logic [31:0] data);
        addr = word_addr(offset);
        din  = data;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic rd(input int offset, input logic [31:0] exp, input string tag);
        push_exp(tag, exp);
        addr = word_addr(offset);
        #1;
        compare(dout);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        push_exp(tag, {31'd0, exp});
        compare({31'd0, irq});
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        din   = 32'd0;
        addr  = word_addr(0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rd(0, 32'd0, "rst_ctrl");
        rd(4, 32'd0, "rst_preset");
        rd(8, 32'd0, "rst_count");
        chk_irq(1'b0, "rst_irq");
        @(negedge clk);
        reset = 1'b0;
        step(1);

        // Mode 0 one-shot, PRESET=5
        wr(4, 32'd5);
        wr(0, 32'h9);                     // E0
        rd(8, 32'd0, "m0_e0_count");
        step(1);
        rd(8, 32'd0, "m0_e1_count");
        step(1);
        rd(8, 32'd5, "m0_e2_count");
        step(4);
        rd(8, 32'd1, "m0_e6_count");
        chk_irq(1'b0, "m0_e6_irq");
        step(1);
        chk_irq(1'b1, "m0_e7_irq");
        rd(8, 32'd0, "m0_e7_count");
        step(1);
        rd(0, 32'h8, "m0_e8_ctrl");
        chk_irq(1'b1, "m0_e8_irq");
        step(3);
        chk_irq(1'b1, "m0_hold_irq");
        rd(8, 32'd0, "m0_hold_count");
        wr(0, 32'h0);
        chk_irq(1'b0, "m0_clear_irq");

        // PRESET=0 behaves as PRESET=1
        wr(4, 32'd0);
        wr(0, 32'h9);                     // E0
        step(2);
        rd(8, 32'd0, "p0_e2_count");
        chk_irq(1'b0, "p0_e2_irq");
        step(1);
        chk_irq(1'b1, "p0_e3_irq");
        rd(8, 32'd0, "p0_e3_count");
        wr(0, 32'h0);
        chk_irq(1'b0, "p0_clear_irq");

        // CTRL write collides with the FSM clearing En in INT
        wr(4, 32'd1);
        wr(0, 32'h9);                     // E0
        step(3);
        chk_irq(1'b1, "col_e3_irq");
        wr(0, 32'h9);                     // E4: INT -> IDLE, write keeps En
        rd(0, 32'h9, "col_e4_ctrl");
        chk_irq(1'b0, "col_e4_irq");
        step(2);
        rd(8, 32'd1, "col_e6_count");
        step(1);
        chk_irq(1'b1, "col_e7_irq");
        wr(0, 32'h0);
        chk_irq(1'b0, "col_clear_irq");

        // Mode 1 auto-reload, PRESET=3: pulse after E5, E11, E17
        wr(4, 32'd3);
        wr(0, 32'hB);                     // E0
        for (int k = 1; k <= 18; k++) begin
            step(1);
            chk_irq((k == 5) || (k == 11) || (k == 17), $sformatf("m1_e%0d_irq", k));
        end
        wr(0, 32'h0);                     // E19
        step(3);
        rd(0, 32'h0, "m1_stop_ctrl");
        rd(8, 32'd3, "m1_stop_count");
        chk_irq(1'b0, "m1_stop_irq");

        // Masked interrupt; CTRL upper bits read as 0
        wr(0, 32'hFFFF_FFF1);             // E0
        rd(0, 32'h1, "mask_ctrl_rd");
        wr(4, 32'd2);                     // E1
        step(4);                          // after E5
        rd(8, 32'd0, "mask_count");
        rd(0, 32'h0, "mask_ctrl_en_cleared");
        chk_irq(1'b0, "mask_irq");
        wr(0, 32'h8);
        rd(0, 32'h8, "mask_ctrl_im");
        chk_irq(1'b0, "mask_irq_after_im");

        // Pause / restart, PRESET=10
        wr(4, 32'd10);
        wr(0, 32'h1);                     // E0
        step(4);
        rd(8, 32'd8, "pause_e4_count");
        wr(0, 32'h0);                     // E5: last decrement to 7
        rd(8, 32'd7, "pause_e5_count");
        step(3);
        rd(8, 32'd7, "pause_hold_count");
        rd(0, 32'h0, "pause_ctrl");
        wr(0, 32'h1);                     // F0
        step(1);
        rd(8, 32'd7, "restart_f1_count");
        step(1);
        rd(8, 32'd10, "restart_f2_count");
        wr(4, 32'd20);                    // F3: running count unaffected
        rd(8, 32'd9, "preset_wr_f3_count");
        step(1);
        rd(8, 32'd8, "preset_wr_f4_count");
        rd(4, 32'd20, "preset_wr_rd");
        step(4);
        rd(8, 32'd4, "pre_reset_count");

        // Async reset mid-count, checked before the next edge
        reset = 1'b1;
        #1;
        rd(0, 32'd0, "async_ctrl");
        rd(4, 32'd0, "async_preset");
        rd(8, 32'd0, "async_count");
        rd(12, 32'd0, "async_rsvd");
        chk_irq(1'b0, "async_irq");
        @(negedge clk);
        reset = 1'b0;
        step(2);
        rd(8, 32'd0, "post_rst_count");
        chk_irq(1'b0, "post_rst_irq");
        wr(8, 32'h55);
        rd(8, 32'd0, "count_wr_ignored");
        wr(12, 32'hFFFF);
        rd(12, 32'd0, "rsvd_reads_zero");
        step(6);
        chk_irq(1'b0, "post_rst_no_irq");
        rd(8, 32'd0, "post_rst_idle_count");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have no parameters; base address decode (0x00007f00 / 0x00007f10) SHALL be done by the bridge, which asserts WE only for in-range, word-aligned, full-byte-enable stores.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Addr  input  30  word address [31:2]; only Addr[3:2] SHALL be decoded.
REQ-005 WE  input  1  register write strobe from the bridge.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  combinational read data for the selected register.
REQ-008 IRQ  output  1  interrupt request to the CP0 hardware-interrupt input.

Function
REQ-009 The register map SHALL be:
- offset 0x0 CTRL: [0] En, [2:1] Mode, [3] IM; bits [31:4] SHALL read as 0.
- offset 0x4 PRESET: read/write.
- offset 0x8 COUNT: read-only.
- offset 0xC: reads 0, writes ignored.
REQ-010 Dout SHALL be a zero-latency combinational mux of Addr[3:2]; there SHALL be no read side effects.
REQ-011 A write to CTRL SHALL store Din[3:0] and clear the internal interrupt flag (IntF).
REQ-012 A write to PRESET SHALL store Din.
REQ-013 A write to COUNT SHALL be ignored.
REQ-014 The FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-015 IDLE: if En==1, go to LOAD; otherwise stay in IDLE.
REQ-016 LOAD: COUNT <= PRESET; go to CNT.
REQ-017 CNT:
- if En==0, go to IDLE and hold COUNT;
- else if COUNT>1, COUNT <= COUNT-1;
- else COUNT <= 0, IntF <= 1, go to INT.
REQ-018 INT, Mode==00: En <= 0, go to IDLE; IntF SHALL remain set until the next CTRL write or reset.
REQ-019 INT, Mode==01: IntF <= 0, go to IDLE with En retained, so IRQ is exactly one cycle wide and the count auto-reloads.
REQ-020 Mode values 10 and 11 SHALL behave as Mode 00.
REQ-021 IRQ SHALL equal IM & IntF, combinationally from registers.
REQ-022 Timing with PRESET=N≥1, starting in IDLE:
- En is set by a CTRL write at edge E0;
- COUNT==N after edge E2;
- COUNT decrements by 1 per edge;
- IRQ rises after edge E(N+2).
REQ-023 Mode 01 reload period: IRQ SHALL pulse every N+3 cycles.
REQ-024 PRESET=0 SHALL behave as PRESET=1: COUNT=0 after the LOAD edge, and INT is entered on the next edge.
REQ-025 A CTRL write on the same edge as an FSM update of En SHALL win: the written En is kept. The FSM state transition on that edge SHALL still occur.
REQ-026 A PRESET write during CNT SHALL NOT affect the running COUNT; it takes effect only at the next LOAD.
REQ-027 Clearing En during CNT SHALL freeze COUNT and return to IDLE. Re-enabling SHALL go through LOAD, so COUNT restarts from PRESET.
REQ-028 COUNT SHALL never wrap below 0.

Reset
REQ-029 On reset, asynchronously: CTRL=0, PRESET=0, COUNT=0, IntF=0, state=IDLE, IRQ=0.
REQ-030 Reset asserted mid-count SHALL abort counting immediately; after release, no IRQ SHALL occur until CTRL is rewritten with En=1.

Verification
REQ-031 Mode 0: write PRESET=5, then CTRL=0x9 at E0 -> COUNT reads 5 after E2 and 1 after E6; IRQ=1 after E7 and stays 1; CTRL reads 0x8 after E8; writing CTRL=0 -> IRQ=0 next cycle.
REQ-032 Mode 1: write PRESET=3, CTRL=0xB -> IRQ is a 1-cycle pulse after E5, E11, E17, ... (period 6).
REQ-033 Masked interrupt: write CTRL=0x1, PRESET=2 -> COUNT reaches 0 and IntF is set, but IRQ stays 0; a later write of CTRL=0x8 clears IntF, so IRQ stays 0.
REQ-034 Pause/restart: PRESET=10, enable, write CTRL=0 when COUNT=7 -> COUNT holds 7; re-enable -> COUNT reloads to 10.
REQ-035 Async reset mid-CNT with COUNT=4: assert reset between edges -> Dout for all offsets and IRQ read 0 before the next edge; offset 0xC always reads 0, and a write to offset 0x8 leaves COUNT unchanged.
